cpu_issue: RTL and testbench
============================

CPU_ISSUE -- requirements
Module: cpu_issue

Interface
REQ-001 Parameter: CTRL_W, 32, width of the opaque decoded-control word passed through to execute.
REQ-002 clk_i  input  1  single clock; all state updates on the rising edge.
REQ-003 rstn_i  input  1  reset, asynchronous and active-low.
REQ-004 flush_i  input  1  kills the instruction held in the issue register.
REQ-005 dec_valid_i  input  1  decoded instruction valid.
REQ-006 dec_ready_o  output  1  issue accepts the decoded instruction this cycle.
REQ-007 dec_rs1_i / dec_rs2_i  input  5 each  source register indices.
REQ-008 dec_rd_i  input  5  destination register index.
REQ-009 dec_use_rs1_i / dec_use_rs2_i  input  1 each  source operand is read.
REQ-010 dec_we_i  input  1  instruction writes rd.
REQ-011 dec_ctrl_i  input  CTRL_W  opaque control word.
REQ-012 rf_raddr1_o / rf_raddr2_o  output  5 each  register-file read addresses; combinational copies of dec_rs1_i / dec_rs2_i.
REQ-013 rf_rdata1_i / rf_rdata2_i  input  32 each  register-file read data, combinational, same cycle.
REQ-014 wb_valid_i  input  1  writeback this cycle; the same port also drives the register-file write.
REQ-015 wb_rd_i  input  5  writeback destination index.
REQ-016 wb_data_i  input  32  writeback data.
REQ-017 ex_valid_o  output  1  issue register holds a valid instruction.
REQ-018 ex_ready_i  input  1  execute consumes the instruction this cycle.
REQ-019 ex_op1_o / ex_op2_o  output  32 each  registered operands.
REQ-020 ex_rd_o  output  5  registered destination index.
REQ-021 ex_we_o  output  1  registered rd write enable.
REQ-022 ex_ctrl_o  output  CTRL_W  registered control word.

Function
REQ-023 Scoreboard: busy[31:1] holds one bit per register; x0 is never busy.
- An operand is zero-index when its index is 0.
- An operand is bypassable when wb_valid_i is set and wb_rd_i equals its index.
REQ-024 A RAW hazard exists when a used, nonzero source is busy and not bypassable.
REQ-025 A WAW hazard exists when dec_we_i is set, dec_rd_i is nonzero, busy[dec_rd_i] is set, and the rd is not cleared by writeback this cycle.
REQ-026 dec_ready_o = !flush_i && !RAW && !WAW && (!ex_valid_o || ex_ready_i); it is combinational and does not depend on dec_valid_i.
REQ-027 Accept occurs when dec_valid_i && dec_ready_o; the issue register loads on the next edge (one-cycle latency).
REQ-028 Operand select on accept, in priority order:
- zero-index -> 0;
- bypassable -> wb_data_i;
- otherwise rf_rdataN_i.
- An unused operand still loads its selected value.
REQ-029 Issue register behaviour:
- On accept, set ex_valid_o.
- Otherwise, if ex_ready_i is set, clear ex_valid_o.
- Otherwise, hold all ex_* outputs stable.
REQ-030 Busy updates at each edge:
- Writeback with nonzero wb_rd_i clears busy[wb_rd_i].
- Accept with dec_we_i and nonzero rd sets busy[dec_rd_i]; set wins over a same-cycle clear of the same index.
REQ-031 flush_i:
- Clears ex_valid_o at the next edge.
- If the killed instruction had ex_we_o and a nonzero ex_rd_o, clears busy[ex_rd_o]; set-wins does not apply because no accept occurs that cycle.
- Instructions already past issue are unaffected and still write back.
REQ-032 ex_ready_i while ex_valid_o is low is ignored; dec_* values are ignored when dec_valid_i is low.

Reset
REQ-033 While rstn_i is low (asynchronous):
- ex_valid_o = 0, ex_we_o = 0, ex_rd_o = 0, ex_op1_o = 0, ex_op2_o = 0, ex_ctrl_o = 0;
- all busy bits = 0.
REQ-034 Reset asserted mid-operation discards the held instruction and all scoreboard state; the first possible accept is in the first cycle after deassertion.

Structure
REQ-035 Package cpu_pkg holds the register-index type (5-bit), the XLEN=32 constant and the default CTRL_W.
REQ-036 Sub-module cpu_scoreboard holds busy[31:1] with set/clear/kill ports and query outputs; cpu_issue instantiates it once.

Verification
REQ-037 Back-to-back independent issue: rs1=x1 (10), rs2=x2 (20), ex_ready_i=1 each cycle -> one issue per cycle; ex_op1_o=10, ex_op2_o=20.
REQ-038 RAW stall: issue rd=x5, then an instruction using rs1=x5 -> dec_ready_o=0 until wb_valid_i with wb_rd_i=5 and wb_data_i=0xABCD. In that cycle, dec_ready_o=1 and ex_op1_o=0xABCD on the next edge.
REQ-039 x0 handling: rs1=0 with rf_rdata1_i=0xFFFFFFFF -> ex_op1_o=0. rd=0 with dec_we_i=1 -> no busy set, and no stall for a following reader of x0.
REQ-040 Backpressure: ex_ready_i=0 for 3 cycles -> ex_* outputs stable and dec_ready_o=0; ex_ready_i=1 -> the next instruction is accepted in the same cycle.
REQ-041 Flush: issued instruction with rd=x7 held, then flush_i=1 -> ex_valid_o=0 next edge, busy[7] clear, and a reader of x7 is accepted the following cycle.
REQ-042 Same-cycle set and clear: wb on x3 while accepting an instruction with rd=x3 -> busy[3]=1 afterwards, so a subsequent reader of x3 stalls.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and constants for the issue stage and its register scoreboard.
package cpu_pkg;

    localparam int XLEN       = 32;
    localparam int CTRL_W_DEF = 32;
    localparam int NREGS      = 32;

    typedef logic [4:0] reg_idx_t;

    // x0 always reads as zero; an in-flight writeback to the same index overrides the register file.
    function automatic logic [XLEN-1:0] sel_operand(
        input reg_idx_t        idx,
        input logic            wb_valid,
        input reg_idx_t        wb_rd,
        input logic [XLEN-1:0] wb_data,
        input logic [XLEN-1:0] rf_data
    );
        logic [XLEN-1:0] res;
        if (idx == '0) begin
            res = '0;
        end else if (wb_valid && (wb_rd == idx)) begin
            res = wb_data;
        end else begin
            res = rf_data;
        end
        return res;
    endfunction

endpackage

// File: rtl/cpu_scoreboard.sv
// Busy-bit scoreboard: one pending-write flag per architectural register, x0 excluded.
module cpu_scoreboard
    import cpu_pkg::*;
(
    input  logic     clk_i,
    input  logic     rstn_i,
    input  logic     set_en_i,
    input  reg_idx_t set_idx_i,
    input  logic     clr_en_i,
    input  reg_idx_t clr_idx_i,
    input  logic     kill_en_i,
    input  reg_idx_t kill_idx_i,
    input  reg_idx_t q_rs1_i,
    input  reg_idx_t q_rs2_i,
    input  reg_idx_t q_rd_i,
    output logic     rs1_busy_o,
    output logic     rs2_busy_o,
    output logic     rd_busy_o
);

    logic [NREGS-1:1] busy_q;
    logic [NREGS-1:1] busy_d;
    logic [NREGS-1:0] busy_vec;

    assign busy_vec   = {busy_q, 1'b0};
    assign rs1_busy_o = busy_vec[q_rs1_i];
    assign rs2_busy_o = busy_vec[q_rs2_i];
    assign rd_busy_o  = busy_vec[q_rd_i];

    // Clears are applied first so a same-cycle set of the same index wins.
    always_comb begin
        busy_d = busy_q;
        for (int i = 1; i < NREGS; i++) begin
            if (clr_en_i && (clr_idx_i == reg_idx_t'(i))) begin
                busy_d[i] = 1'b0;
            end
            if (kill_en_i && (kill_idx_i == reg_idx_t'(i))) begin
                busy_d[i] = 1'b0;
            end
            if (set_en_i && (set_idx_i == reg_idx_t'(i))) begin
                busy_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

endmodule

// File: rtl/cpu_issue.sv
// In-order issue stage: hazard check against the scoreboard, operand read with writeback
// bypass, and a single issue register feeding execute.
module cpu_issue
    import cpu_pkg::*;
#(
    parameter int CTRL_W = CTRL_W_DEF
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              flush_i,
    input  logic              dec_valid_i,
    output logic              dec_ready_o,
    input  logic [4:0]        dec_rs1_i,
    input  logic [4:0]        dec_rs2_i,
    input  logic [4:0]        dec_rd_i,
    input  logic              dec_use_rs1_i,
    input  logic              dec_use_rs2_i,
    input  logic              dec_we_i,
    input  logic [CTRL_W-1:0] dec_ctrl_i,
    output logic [4:0]        rf_raddr1_o,
    output logic [4:0]        rf_raddr2_o,
    input  logic [XLEN-1:0]   rf_rdata1_i,
    input  logic [XLEN-1:0]   rf_rdata2_i,
    input  logic              wb_valid_i,
    input  logic [4:0]        wb_rd_i,
    input  logic [XLEN-1:0]   wb_data_i,
    output logic              ex_valid_o,
    input  logic              ex_ready_i,
    output logic [XLEN-1:0]   ex_op1_o,
    output logic [XLEN-1:0]   ex_op2_o,
    output logic [4:0]        ex_rd_o,
    output logic              ex_we_o,
    output logic [CTRL_W-1:0] ex_ctrl_o
);

    // Handshake: a transfer happens on an edge where valid && ready are both high.
    // dec_ready_o never looks at dec_valid_i; ex_valid_o, once high, holds with stable
    // payload until ex_ready_i is seen or a flush kills it.

    logic rs1_busy, rs2_busy, rd_busy;
    logic rs1_byp, rs2_byp;
    logic raw_haz, waw_haz;
    logic accept;
    logic wb_clr;
    logic kill;

    assign rf_raddr1_o = dec_rs1_i;
    assign rf_raddr2_o = dec_rs2_i;

    assign rs1_byp = wb_valid_i && (wb_rd_i == dec_rs1_i);
    assign rs2_byp = wb_valid_i && (wb_rd_i == dec_rs2_i);

    // Busy bits of x0 read as zero, so the nonzero-index test is implicit here.
    assign raw_haz = (dec_use_rs1_i && rs1_busy && !rs1_byp)
                  || (dec_use_rs2_i && rs2_busy && !rs2_byp);
    assign waw_haz = dec_we_i && (dec_rd_i != '0) && rd_busy
                  && !(wb_valid_i && (wb_rd_i == dec_rd_i));

    assign dec_ready_o = !flush_i && !raw_haz && !waw_haz && (!ex_valid_o || ex_ready_i);
    assign accept      = dec_valid_i && dec_ready_o;
    assign wb_clr      = wb_valid_i && (wb_rd_i != '0);
    assign kill        = flush_i && ex_valid_o && ex_we_o && (ex_rd_o != '0);

    cpu_scoreboard u_sb (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .set_en_i   (accept && dec_we_i && (dec_rd_i != '0)),
        .set_idx_i  (dec_rd_i),
        .clr_en_i   (wb_clr),
        .clr_idx_i  (wb_rd_i),
        .kill_en_i  (kill),
        .kill_idx_i (ex_rd_o),
        .q_rs1_i    (dec_rs1_i),
        .q_rs2_i    (dec_rs2_i),
        .q_rd_i     (dec_rd_i),
        .rs1_busy_o (rs1_busy),
        .rs2_busy_o (rs2_busy),
        .rd_busy_o  (rd_busy)
    );

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ex_valid_o <= 1'b0;
            ex_op1_o   <= '0;
            ex_op2_o   <= '0;
            ex_rd_o    <= '0;
            ex_we_o    <= 1'b0;
            ex_ctrl_o  <= '0;
        end else if (accept) begin
            ex_valid_o <= 1'b1;
            ex_op1_o   <= sel_operand(dec_rs1_i, wb_valid_i, wb_rd_i, wb_data_i, rf_rdata1_i);
            ex_op2_o   <= sel_operand(dec_rs2_i, wb_valid_i, wb_rd_i, wb_data_i, rf_rdata2_i);
            ex_rd_o    <= dec_rd_i;
            ex_we_o    <= dec_we_i;
            ex_ctrl_o  <= dec_ctrl_i;
        end else if (flush_i || ex_ready_i) begin
            ex_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cpu_issue.sv
// Directed bench for cpu_issue: drivers push expected issue payloads, a monitor checks each
// instruction as execute consumes it.
module tb_cpu_issue;
    import cpu_pkg::*;

    localparam int CW = 32;
    localparam int EW = 32 + 32 + 5 + 1 + CW;

    logic          clk_i = 1'b0;
    logic          rstn_i;
    logic          flush_i;
    logic          dec_valid_i;
    logic          dec_ready_o;
    logic [4:0]    dec_rs1_i, dec_rs2_i, dec_rd_i;
    logic          dec_use_rs1_i, dec_use_rs2_i, dec_we_i;
    logic [CW-1:0] dec_ctrl_i;
    logic [4:0]    rf_raddr1_o, rf_raddr2_o;
    logic [31:0]   rf_rdata1_i, rf_rdata2_i;
    logic          wb_valid_i;
    logic [4:0]    wb_rd_i;
    logic [31:0]   wb_data_i;
    logic          ex_valid_o;
    logic          ex_ready_i;
    logic [31:0]   ex_op1_o, ex_op2_o;
    logic [4:0]    ex_rd_o;
    logic          ex_we_o;
    logic [CW-1:0] ex_ctrl_o;

    logic [EW-1:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    cpu_issue #(.CTRL_W(CW)) dut (
        .clk_i         (clk_i),
        .rstn_i        (rstn_i),
        .flush_i       (flush_i),
        .dec_valid_i   (dec_valid_i),
        .dec_ready_o   (dec_ready_o),
        .dec_rs1_i     (dec_rs1_i),
        .dec_rs2_i     (dec_rs2_i),
        .dec_rd_i      (dec_rd_i),
        .dec_use_rs1_i (dec_use_rs1_i),
        .dec_use_rs2_i (dec_use_rs2_i),
        .dec_we_i      (dec_we_i),
        .dec_ctrl_i    (dec_ctrl_i),
        .rf_raddr1_o   (rf_raddr1_o),
        .rf_raddr2_o   (rf_raddr2_o),
        .rf_rdata1_i   (rf_rdata1_i),
        .rf_rdata2_i   (rf_rdata2_i),
        .wb_valid_i    (wb_valid_i),
        .wb_rd_i       (wb_rd_i),
        .wb_data_i     (wb_data_i),
        .ex_valid_o    (ex_valid_o),
        .ex_ready_i    (ex_ready_i),
        .ex_op1_o      (ex_op1_o),
        .ex_op2_o      (ex_op2_o),
        .ex_rd_o       (ex_rd_o),
        .ex_we_o       (ex_we_o),
        .ex_ctrl_o     (ex_ctrl_o)
    );

    // clock / reset
    always #5 clk_i = ~clk_i;

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [EW-1:0] pack(input logic [31:0] op1, input logic [31:0] op2,
                                           input logic [4:0] rd, input logic we,
                                           input logic [CW-1:0] ctrl);
        return {op1, op2, rd, we, ctrl};
    endfunction

    // driver
    task automatic set_dec(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                           input logic u1, input logic u2, input logic we,
                           input logic [31:0] d1, input logic [31:0] d2, input logic [CW-1:0] ctrl);
        dec_valid_i   = 1'b1;
        dec_rs1_i     = rs1;
        dec_rs2_i     = rs2;
        dec_rd_i      = rd;
        dec_use_rs1_i = u1;
        dec_use_rs2_i = u2;
        dec_we_i      = we;
        rf_rdata1_i   = d1;
        rf_rdata2_i   = d2;
        dec_ctrl_i    = ctrl;
    endtask

    task automatic idle();
        dec_valid_i = 1'b0;
        wb_valid_i  = 1'b0;
        flush_i     = 1'b0;
    endtask

    // monitor / scoreboard
    always @(negedge clk_i) begin
        if (rstn_i && ex_valid_o && ex_ready_i) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_issue", {ex_op1_o, ex_op2_o, ex_rd_o, ex_we_o, ex_ctrl_o}, '0);
            end else begin
                chk("issue_payload", {ex_op1_o, ex_op2_o, ex_rd_o, ex_we_o, ex_ctrl_o},
                    exp_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        rstn_i = 1'b0;
        ex_ready_i = 1'b0;
        wb_rd_i = '0;
        wb_data_i = '0;
        idle();
        set_dec(0, 0, 0, 0, 0, 0, 0, 0, 0);
        dec_valid_i = 1'b0;
        cyc();
        cyc();
        chk("rst_valid", ex_valid_o, 0);
        chk("rst_we", ex_we_o, 0);
        chk("rst_rd", ex_rd_o, 0);
        chk("rst_op1", ex_op1_o, 0);
        chk("rst_op2", ex_op2_o, 0);
        chk("rst_ctrl", ex_ctrl_o, 0);
        rstn_i = 1'b1;
        cyc();

        // back-to-back independent issue
        ex_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_dec(5'd1, 5'd2, 5'(10 + i), 1, 1, 1, 32'd10, 32'd20, 32'hA0 + i);
            #1;
            chk("b2b_ready", dec_ready_o, 1);
            chk("b2b_raddr1", rf_raddr1_o, 1);
            exp_q.push_back(pack(32'd10, 32'd20, 5'(10 + i), 1'b1, 32'hA0 + i));
            cyc();
        end
        idle();
        cyc();
        cyc();

        // RAW stall on x5, released by writeback bypass
        set_dec(5'd1, 5'd2, 5'd5, 1, 1, 1, 32'd10, 32'd20, 32'hB0);
        exp_q.push_back(pack(32'd10, 32'd20, 5'd5, 1'b1, 32'hB0));
        cyc();
        set_dec(5'd5, 5'd2, 5'd6, 1, 0, 0, 32'h1111, 32'h22, 32'hB1);
        #1;
        chk("raw_stall0", dec_ready_o, 0);
        cyc();
        chk("raw_stall1", dec_ready_o, 0);
        wb_valid_i = 1'b1;
        wb_rd_i    = 5'd5;
        wb_data_i  = 32'hABCD;
        #1;
        chk("raw_release", dec_ready_o, 1);
        exp_q.push_back(pack(32'hABCD, 32'h22, 5'd6, 1'b0, 32'hB1));
        cyc();
        idle();
        cyc();

        // x0 handling
        set_dec(5'd0, 5'd0, 5'd0, 1, 1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hC0);
        #1;
        chk("x0_ready", dec_ready_o, 1);
        exp_q.push_back(pack(32'd0, 32'd0, 5'd0, 1'b1, 32'hC0));
        cyc();
        set_dec(5'd0, 5'd1, 5'd0, 1, 1, 1, 32'hFFFF_FFFF, 32'h5, 32'hC1);
        #1;
        chk("x0_reader_ready", dec_ready_o, 1);
        exp_q.push_back(pack(32'd0, 32'h5, 5'd0, 1'b1, 32'hC1));
        cyc();
        idle();
        cyc();

        // backpressure
        ex_ready_i = 1'b0;
        set_dec(5'd1, 5'd2, 5'd13, 1, 1, 0, 32'h100, 32'h200, 32'hD0);
        #1;
        chk("bp_first_ready", dec_ready_o, 1);
        exp_q.push_back(pack(32'h100, 32'h200, 5'd13, 1'b0, 32'hD0));
        cyc();
        set_dec(5'd1, 5'd2, 5'd14, 1, 1, 0, 32'h300, 32'h400, 32'hD1);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_ready_low", dec_ready_o, 0);
            chk("bp_valid_hold", ex_valid_o, 1);
            chk("bp_op1_hold", ex_op1_o, 32'h100);
            chk("bp_ctrl_hold", ex_ctrl_o, 32'hD0);
            cyc();
        end
        ex_ready_i = 1'b1;
        #1;
        chk("bp_release", dec_ready_o, 1);
        exp_q.push_back(pack(32'h300, 32'h400, 5'd14, 1'b0, 32'hD1));
        cyc();
        idle();
        cyc();

        // flush of a held writer to x7
        ex_ready_i = 1'b0;
        set_dec(5'd1, 5'd2, 5'd7, 1, 1, 1, 32'h70, 32'h71, 32'hE0);
        cyc();
        idle();
        flush_i = 1'b1;
        #1;
        chk("flush_ready_low", dec_ready_o, 0);
        cyc();
        flush_i = 1'b0;
        chk("flush_valid", ex_valid_o, 0);
        ex_ready_i = 1'b1;
        set_dec(5'd7, 5'd2, 5'd8, 1, 1, 0, 32'h77, 32'h78, 32'hE1);
        #1;
        chk("flush_reader_ready", dec_ready_o, 1);
        exp_q.push_back(pack(32'h77, 32'h78, 5'd8, 1'b0, 32'hE1));
        cyc();
        idle();
        cyc();

        // same-cycle set and clear on x3
        set_dec(5'd1, 5'd2, 5'd3, 0, 0, 1, 32'h1, 32'h2, 32'hF0);
        exp_q.push_back(pack(32'h1, 32'h2, 5'd3, 1'b1, 32'hF0));
        cyc();
        idle();
        cyc();
        set_dec(5'd3, 5'd2, 5'd3, 1, 1, 1, 32'h999, 32'h2, 32'hF1);
        wb_valid_i = 1'b1;
        wb_rd_i    = 5'd3;
        wb_data_i  = 32'h33;
        #1;
        chk("setclr_ready", dec_ready_o, 1);
        exp_q.push_back(pack(32'h33, 32'h2, 5'd3, 1'b1, 32'hF1));
        cyc();
        wb_valid_i = 1'b0;
        set_dec(5'd1, 5'd2, 5'd3, 0, 0, 1, 32'h1, 32'h2, 32'hF2);
        #1;
        chk("waw_stall", dec_ready_o, 0);
        set_dec(5'd3, 5'd2, 5'd4, 1, 0, 0, 32'h999, 32'h2, 32'hF3);
        #1;
        chk("setclr_reader_stall", dec_ready_o, 0);
        cyc();
        wb_valid_i = 1'b1;
        wb_rd_i    = 5'd3;
        wb_data_i  = 32'h44;
        #1;
        chk("setclr_reader_release", dec_ready_o, 1);
        exp_q.push_back(pack(32'h44, 32'h2, 5'd4, 1'b0, 32'hF3));
        cyc();
        idle();
        cyc();

        // reset mid-operation drops held writer and scoreboard
        ex_ready_i = 1'b0;
        set_dec(5'd1, 5'd2, 5'd9, 1, 1, 1, 32'h90, 32'h91, 32'h1A);
        cyc();
        idle();
        chk("midrst_held", ex_valid_o, 1);
        rstn_i = 1'b0;
        #1;
        chk("midrst_valid", ex_valid_o, 0);
        chk("midrst_op1", ex_op1_o, 0);
        cyc();
        rstn_i = 1'b1;
        ex_ready_i = 1'b1;
        set_dec(5'd9, 5'd10, 5'd0, 1, 1, 0, 32'h99, 32'hAA, 32'h1B);
        #1;
        chk("midrst_first_accept", dec_ready_o, 1);
        exp_q.push_back(pack(32'h99, 32'hAA, 5'd0, 1'b0, 32'h1B));
        cyc();
        idle();
        cyc();
        cyc();

        chk("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
